sum_sipo_collector: RTL and testbench
=====================================

// Module: sum_sipo_collector
// PURPOSE
//  Serial-in parallel-out result stage downstream of the Mealy serial adder.
//  Shifts in the adder's sum bits LSB-first, one per qualified cycle, and captures the final carry.
//  Presents the completed DATA_WIDTH-bit sum with a valid/ready handshake to the consumer.
//  Tracks bit position internally and uses the bit-valid strobe from the adder controller.
// PARAMETERS
//  DATA_WIDTH  8  width of assembled sum word (bits per serial operation)
//  CNT_WIDTH   4  width of internal bit counter; must satisfy 2**CNT_WIDTH > DATA_WIDTH
// PORTS
//  i_clk      input   1           clock; all state updates on rising edge
//  reset      input   1           asynchronous, active-low reset (0 = reset asserted)
//  start      input   1           begin collection of a new word (one-cycle pulse)
//  bit_valid  input   1           sum_bit/carry_bit are valid this cycle
//  sum_bit    input   1           serial sum bit from adder, LSB first
//  carry_bit  input   1           adder carry-out accompanying sum_bit
//  i_ready    input   1           consumer accepts o_sum this cycle
//  o_sum      output  DATA_WIDTH  assembled sum; stable while o_valid=1
//  o_carry    output  1           carry-out of final (MSB) bit
//  o_valid    output  1           o_sum/o_carry hold a complete result
//  o_busy     output  1           collection in progress (state COLLECT)
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, shift reg=0, bit_cnt=0, o_sum=0, o_carry=0, o_valid=0, o_busy=0.
//  FSM states: IDLE, COLLECT, HOLD.
//  IDLE:
//   - start=1 -> COLLECT; shift reg cleared, bit_cnt=0.
//   - bit_valid is ignored.
//  COLLECT (o_busy=1):
//   - bit_valid=1 -> shift reg <= {sum_bit, shift[DATA_WIDTH-1:1]}; bit_cnt+1.
//   - bit_valid=0 -> hold; gaps of any length are allowed.
//   - If bit_valid=1 and bit_cnt==DATA_WIDTH-1, the next edge does all of the following:
//       o_sum <= completed word; o_carry <= carry_bit; o_valid <= 1; state -> HOLD.
//     This is 1-cycle latency from the last bit to o_valid.
//   - start=1 in COLLECT aborts the current word: shift reg cleared, bit_cnt=0, stay COLLECT.
//     start has priority over bit_valid in the same cycle.
//  HOLD (o_valid=1):
//   - o_sum/o_carry are frozen; bit_valid is ignored.
//   - i_ready=1 -> o_valid=0 next edge; state -> IDLE, or -> COLLECT if start=1 in the same cycle.
//   - start=1 with i_ready=0 is ignored. The start is not queued.
//  o_sum and o_carry retain the last result after handshake until the next completion. Only o_valid qualifies them.
//  bit_cnt never exceeds DATA_WIDTH-1 and has no wrap; the completion transition resets it to 0.
//  No combinational path from any input to any output; all outputs are registered.
// TESTING
//  1 Reset: assert reset=0 mid-COLLECT after 3 bits -> next sample o_valid=0, o_busy=0, o_sum=0; a fresh start then collects a full word.
//  2 Basic: start, then 8 consecutive bit_valid with sum bits of 0xE1 LSB-first (1,0,0,0,0,1,1,1), final carry 0
//    -> o_valid=1 one cycle after the 8th bit, o_sum=0xE1, o_carry=0.
//  3 Carry/gaps: sum 0x00 with final carry_bit=1 (0xFF+0x01), bit_valid low for 2 cycles between bits 3 and 4
//    -> o_sum=0x00, o_carry=1, o_valid after the 8th valid bit only.
//  4 Backpressure: hold i_ready=0 for 5 cycles in HOLD, toggle sum_bit/bit_valid and pulse start
//    -> o_sum unchanged, o_valid stays 1; i_ready=1 -> o_valid=0 next cycle, state IDLE.
//  5 Abort/restart: start, 4 bits, start again, then 8 bits of 0x5A -> o_sum=0x5A; the first partial bits are discarded.
//  6 Back-to-back: i_ready=1 and start=1 in the same HOLD cycle, then 8 bits of 0x3C -> o_busy=1 next cycle, second result o_sum=0x3C.

Source files
------------

// File: rtl/sum_sipo_collector.sv
// Serial-in parallel-out collector for the serial adder's sum/carry bits.
// Ports: i_clk, reset (async, active-low), start, bit_valid, sum_bit,
//        carry_bit, i_ready -> o_sum[DATA_WIDTH], o_carry, o_valid, o_busy.
module sum_sipo_collector #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  i_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  bit_valid,
    input  logic                  sum_bit,
    input  logic                  carry_bit,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_sum,
    output logic                  o_carry,
    output logic                  o_valid,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_sum;
    logic                  r_carry;
    logic                  r_valid;
    logic                  r_busy;
    logic                  w_valid_nxt;
    logic                  w_busy_nxt;
    logic                  w_last;
    logic                  w_clear;
    logic                  w_shift_en;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] w_shift_nxt;

    assign w_last      = (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1));
    assign w_shift_nxt = {sum_bit, r_shift[DATA_WIDTH-1:1]};

    // A start is honoured everywhere except in HOLD without a handshake.
    assign w_clear    = start && ((r_state != S_HOLD) || i_ready);
    assign w_shift_en = (r_state == S_COLLECT) && !start && bit_valid;
    assign w_done     = w_shift_en && w_last;

    // State register
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                if (start)       w_state_nxt = S_COLLECT;
                else if (w_done) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (i_ready) w_state_nxt = start ? S_COLLECT : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output logic: flags follow the next state so they come out of flops
    always_comb begin
        w_valid_nxt = (w_state_nxt == S_HOLD);
        w_busy_nxt  = (w_state_nxt == S_COLLECT);
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Shift register and bit counter
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_clear) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_done) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_shift_en) begin
            r_shift <= w_shift_nxt;
            r_cnt   <= r_cnt + CNT_WIDTH'(1);
        end
    end

    // Result registers keep the last word until the next completion
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else if (w_done) begin
            r_sum   <= w_shift_nxt;
            r_carry <= carry_bit;
        end
    end

    assign o_sum   = r_sum;
    assign o_carry = r_carry;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;

endmodule

// File: tb/tb_sum_sipo_collector.sv
// Directed testbench for sum_sipo_collector.
// Drives serial words and checks the assembled result and handshake.
module tb_sum_sipo_collector;

    logic       i_clk = 1'b0;
    logic       reset;
    logic       start;
    logic       bit_valid;
    logic       sum_bit;
    logic       carry_bit;
    logic       i_ready;
    logic [7:0] o_sum;
    logic       o_carry;
    logic       o_valid;
    logic       o_busy;

    int vectors = 0;
    int errors  = 0;

    sum_sipo_collector #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut (
        .i_clk     (i_clk),
        .reset     (reset),
        .start     (start),
        .bit_valid (bit_valid),
        .sum_bit   (sum_bit),
        .carry_bit (carry_bit),
        .i_ready   (i_ready),
        .o_sum     (o_sum),
        .o_carry   (o_carry),
        .o_valid   (o_valid),
        .o_busy    (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input logic c);
        bit_valid = 1'b1;
        sum_bit   = b;
        carry_bit = c;
        tick();
        bit_valid = 1'b0;
        sum_bit   = 1'b0;
        carry_bit = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input logic c);
        for (int i = 0; i < 8; i++) begin
            send_bit(w[i], (i == 7) ? c : 1'b0);
            if (i == 6) chk("valid_before_last", {31'd0, o_valid}, 32'd0);
        end
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        bit_valid = 1'b0;
        sum_bit   = 1'b0;
        carry_bit = 1'b0;
        i_ready   = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_busy",  {31'd0, o_busy},  32'd0);
        chk("rst_sum",   {24'd0, o_sum},   32'h00);
        chk("rst_carry", {31'd0, o_carry}, 32'd0);

        // Basic word 0xE1, carry 0
        pulse_start();
        chk("basic_busy", {31'd0, o_busy}, 32'd1);
        send_word(8'hE1, 1'b0);
        chk("basic_valid", {31'd0, o_valid}, 32'd1);
        chk("basic_sum",   {24'd0, o_sum},   32'hE1);
        chk("basic_carry", {31'd0, o_carry}, 32'd0);
        chk("basic_nbusy", {31'd0, o_busy},  32'd0);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("basic_ack_valid", {31'd0, o_valid}, 32'd0);
        chk("basic_keep_sum",  {24'd0, o_sum},   32'hE1);

        // Sum 0x00 with carry 1, two idle cycles after the third bit
        pulse_start();
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1);
        tick();
        chk("gap_valid0", {31'd0, o_valid}, 32'd0);
        tick();
        chk("gap_busy", {31'd0, o_busy}, 32'd1);
        for (int i = 3; i < 8; i++) begin
            send_bit(1'b0, 1'b1);
            if (i == 6) chk("gap_valid_early", {31'd0, o_valid}, 32'd0);
        end
        chk("gap_valid", {31'd0, o_valid}, 32'd1);
        chk("gap_sum",   {24'd0, o_sum},   32'h00);
        chk("gap_carry", {31'd0, o_carry}, 32'd1);

        // Backpressure: HOLD ignores bits and start without ready
        sum_bit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bit_valid = ~bit_valid;
            start     = (i == 2);
            tick();
            chk("bp_valid", {31'd0, o_valid}, 32'd1);
            chk("bp_sum",   {24'd0, o_sum},   32'h00);
        end
        start     = 1'b0;
        bit_valid = 1'b0;
        sum_bit   = 1'b0;
        chk("bp_carry", {31'd0, o_carry}, 32'd1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("bp_ack_valid", {31'd0, o_valid}, 32'd0);
        chk("bp_idle_busy", {31'd0, o_busy},  32'd0);
        tick();
        chk("bp_no_queue", {31'd0, o_busy}, 32'd0);

        // Abort after 4 bits, then 0x5A
        pulse_start();
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
        pulse_start();
        chk("abort_busy", {31'd0, o_busy}, 32'd1);
        send_word(8'h5A, 1'b0);
        chk("abort_valid", {31'd0, o_valid}, 32'd1);
        chk("abort_sum",   {24'd0, o_sum},   32'h5A);
        chk("abort_carry", {31'd0, o_carry}, 32'd0);

        // Back-to-back: ready and start together in HOLD
        i_ready = 1'b1;
        start   = 1'b1;
        tick();
        i_ready = 1'b0;
        start   = 1'b0;
        chk("b2b_valid", {31'd0, o_valid}, 32'd0);
        chk("b2b_busy",  {31'd0, o_busy},  32'd1);
        send_word(8'h3C, 1'b1);
        chk("b2b_valid2", {31'd0, o_valid}, 32'd1);
        chk("b2b_sum",    {24'd0, o_sum},   32'h3C);
        chk("b2b_carry",  {31'd0, o_carry}, 32'd1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;

        // Async reset mid-collection after 3 bits
        pulse_start();
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        reset = 1'b0;
        #1;
        chk("arst_valid", {31'd0, o_valid}, 32'd0);
        chk("arst_busy",  {31'd0, o_busy},  32'd0);
        chk("arst_sum",   {24'd0, o_sum},   32'h00);
        chk("arst_carry", {31'd0, o_carry}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        pulse_start();
        send_word(8'hA5, 1'b0);
        chk("post_rst_valid", {31'd0, o_valid}, 32'd1);
        chk("post_rst_sum",   {24'd0, o_sum},   32'hA5);
        chk("post_rst_carry", {31'd0, o_carry}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
